// File: rtl/video_ts_pkg.sv
// Shared definitions for the TS sprite-line scanner: FSM encoding and
// sprite descriptor field positions.
package video_ts_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD0  = 3'd1,
    CHK0 = 3'd2,
    RD1  = 3'd3,
    CHK2 = 3'd4,
    EMIT = 3'd5,
    DONE = 3'd6
  } scan_state_t;

  // Each sprite descriptor is three consecutive sprite-file words
  localparam int SPR_WORDS = 3;

  // R0: Y placement and flags
  localparam int R0_Y_LSB     = 0;
  localparam int R0_YSZ_LSB   = 9;
  localparam int R0_ACT_BIT   = 13;
  localparam int R0_LEAP_BIT  = 14;
  localparam int R0_YFLIP_BIT = 15;

  // R1: X placement
  localparam int R1_X_LSB     = 0;
  localparam int R1_XSZ_LSB   = 9;
  localparam int R1_XFLIP_BIT = 15;

  // R2: graphics and palette
  localparam int R2_TNUM_LSB  = 0;
  localparam int R2_PAL_LSB   = 12;

endpackage

// File: rtl/video_ts_spr_geom.sv
// Combinational sprite geometry: Y visibility against the current line,
// in-sprite line offset (with Y flip) and off-screen X culling.
module video_ts_spr_geom #(
  parameter int CULL_X = 1,
  parameter int VIS_W  = 360
) (
  input  logic [8:0] line,
  input  logic [8:0] y,
  input  logic [2:0] ysz,
  input  logic       act,
  input  logic       yflip,
  input  logic [8:0] x,
  input  logic [2:0] xsz,
  output logic       vis,
  output logic [5:0] offset,
  output logic       cull
);

  logic [8:0] sline;
  logic [5:0] ymax;
  logic [3:0] xs1;
  logic [9:0] x_end;

  // Y math wraps modulo 512; X end is kept in 10 bits so wrap-around
  // sprites (end beyond 512) are recognised as partly visible on the left.
  always_comb begin
    sline  = line - y;
    ymax   = {ysz, 3'b111};
    vis    = act & (sline <= {3'b000, ymax});
    offset = yflip ? (ymax - sline[5:0]) : sline[5:0];
    xs1    = {1'b0, xsz} + 4'd1;
    x_end  = {1'b0, x} + {3'b000, xs1, 3'b000};
    cull   = (CULL_X != 0) & ({1'b0, x} >= 10'(VIS_W)) & (x_end <= 10'd512);
  end

endmodule

// File: rtl/video_ts_spr_scan.sv
// Per-line sprite scanner: walks the sprite file, selects sprites visible on
// the current line, splits them into z-layers and issues render tasks.
module video_ts_spr_scan
  import video_ts_pkg::*;
#(
  parameter int SPR_NUM      = 85,
  parameter int SF_AW        = 8,
  parameter int LAYERS       = 3,
  parameter int MAX_PER_LINE = 64,
  parameter int CULL_X       = 1,
  parameter int VIS_W        = 360
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              en,
  input  logic [8:0]        line,
  output logic [SF_AW-1:0]  sf_addr,
  input  logic [15:0]       sf_rdata,
  input  logic              tsr_rdy,
  output logic              tsr_go,
  output logic [8:0]        tsr_x,
  output logic [2:0]        tsr_xs,
  output logic              tsr_xf,
  output logic [8:0]        tsr_line,
  output logic [5:0]        tsr_addr,
  output logic [3:0]        tsr_pal,
  output logic [LAYERS-1:0] layer_end,
  output logic              busy,
  output logic              ovf,
  output logic [6:0]        spr_cnt
);

  localparam int IW = (SPR_NUM > 1) ? $clog2(SPR_NUM) : 1;
  localparam int LW = $clog2(LAYERS + 1);

  scan_state_t       state_reg, state_next;
  logic [IW-1:0]     idx_reg, idx_next;
  logic [LW-1:0]     layer_reg, layer_next;
  logic [6:0]        spr_cnt_reg, spr_cnt_next;
  logic              ovf_reg, ovf_next;
  logic [5:0]        offset_reg, offset_next;
  logic              leap_reg, leap_next;
  logic              cull_reg, cull_next;
  logic [8:0]        tsr_x_reg, tsr_x_next;
  logic [2:0]        tsr_xs_reg, tsr_xs_next;
  logic              tsr_xf_reg, tsr_xf_next;
  logic [8:0]        tsr_line_reg, tsr_line_next;
  logic [5:0]        tsr_addr_reg, tsr_addr_next;
  logic [3:0]        tsr_pal_reg, tsr_pal_next;
  logic [LAYERS-1:0] layer_end_reg, layer_end_next;

  logic              g_vis, g_cull;
  logic [5:0]        g_offset;
  logic              cur_leap, capped, complete;
  logic [LW-1:0]     layer_after;
  logic [LAYERS-1:0] layer_hot, tail_mask;
  logic [SF_AW-1:0]  addr_base;

  // R0 and R1 both arrive on sf_rdata, in different states, so the same word
  // feeds the Y and X halves of the geometry block.
  video_ts_spr_geom #(.CULL_X(CULL_X), .VIS_W(VIS_W)) u_geom (
    .line   (line),
    .y      (sf_rdata[R0_Y_LSB +: 9]),
    .ysz    (sf_rdata[R0_YSZ_LSB +: 3]),
    .act    (sf_rdata[R0_ACT_BIT]),
    .yflip  (sf_rdata[R0_YFLIP_BIT]),
    .x      (sf_rdata[R1_X_LSB +: 9]),
    .xsz    (sf_rdata[R1_XSZ_LSB +: 3]),
    .vis    (g_vis),
    .offset (g_offset),
    .cull   (g_cull)
  );

  // In CHK0 the leap bit is still on the bus; later states use the latched copy
  assign cur_leap    = (state_reg == CHK0) ? sf_rdata[R0_LEAP_BIT] : leap_reg;
  assign capped      = (MAX_PER_LINE != 0) && (spr_cnt_reg >= 7'(MAX_PER_LINE));
  assign layer_after = layer_reg + LW'(cur_leap);
  assign addr_base   = SF_AW'(idx_reg) * SF_AW'(SPR_WORDS);

  // Current-layer one-hot and the "this layer and above" mask used at DONE
  generate
    for (genvar gi = 0; gi < LAYERS; gi++) begin : g_layer
      assign layer_hot[gi] = (layer_reg == LW'(gi));
      assign tail_mask[gi] = (LW'(gi) >= layer_after);
    end
  endgenerate

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      idx_reg       <= '0;
      layer_reg     <= '0;
      spr_cnt_reg   <= '0;
      ovf_reg       <= 1'b0;
      offset_reg    <= '0;
      leap_reg      <= 1'b0;
      cull_reg      <= 1'b0;
      tsr_x_reg     <= '0;
      tsr_xs_reg    <= '0;
      tsr_xf_reg    <= 1'b0;
      tsr_line_reg  <= '0;
      tsr_addr_reg  <= '0;
      tsr_pal_reg   <= '0;
      layer_end_reg <= '0;
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      layer_reg     <= layer_next;
      spr_cnt_reg   <= spr_cnt_next;
      ovf_reg       <= ovf_next;
      offset_reg    <= offset_next;
      leap_reg      <= leap_next;
      cull_reg      <= cull_next;
      tsr_x_reg     <= tsr_x_next;
      tsr_xs_reg    <= tsr_xs_next;
      tsr_xf_reg    <= tsr_xf_next;
      tsr_line_reg  <= tsr_line_next;
      tsr_addr_reg  <= tsr_addr_next;
      tsr_pal_reg   <= tsr_pal_next;
      layer_end_reg <= layer_end_next;
    end
  end

  // Next-state, sprite-file address and task strobe; start overrides all
  always_comb begin
    state_next     = state_reg;
    idx_next       = idx_reg;
    layer_next     = layer_reg;
    spr_cnt_next   = spr_cnt_reg;
    ovf_next       = ovf_reg;
    offset_next    = offset_reg;
    leap_next      = leap_reg;
    cull_next      = cull_reg;
    tsr_x_next     = tsr_x_reg;
    tsr_xs_next    = tsr_xs_reg;
    tsr_xf_next    = tsr_xf_reg;
    tsr_line_next  = tsr_line_reg;
    tsr_addr_next  = tsr_addr_reg;
    tsr_pal_next   = tsr_pal_reg;
    layer_end_next = '0;
    sf_addr        = '0;
    tsr_go         = 1'b0;
    complete       = 1'b0;

    case (state_reg)
      RD0: begin
        sf_addr    = addr_base;
        state_next = CHK0;
      end
      CHK0: begin
        offset_next = g_offset;
        leap_next   = sf_rdata[R0_LEAP_BIT];
        if (g_vis && !capped) begin
          sf_addr    = addr_base + SF_AW'(1);
          state_next = RD1;
        end else begin
          complete = 1'b1;
        end
      end
      RD1: begin
        sf_addr     = addr_base + SF_AW'(2);
        tsr_x_next  = sf_rdata[R1_X_LSB +: 9];
        tsr_xs_next = sf_rdata[R1_XSZ_LSB +: 3];
        tsr_xf_next = sf_rdata[R1_XFLIP_BIT];
        cull_next   = g_cull;
        state_next  = CHK2;
      end
      CHK2: begin
        tsr_line_next = {sf_rdata[R2_TNUM_LSB + 6 +: 6], 3'b000} + {3'b000, offset_reg};
        tsr_addr_next = sf_rdata[R2_TNUM_LSB +: 6];
        tsr_pal_next  = sf_rdata[R2_PAL_LSB +: 4];
        if (cull_reg) complete = 1'b1;
        else          state_next = EMIT;
      end
      EMIT: begin
        tsr_go = tsr_rdy;
        if (tsr_rdy) begin
          spr_cnt_next = spr_cnt_reg + 7'd1;
          if ((MAX_PER_LINE != 0) && (spr_cnt_next == 7'(MAX_PER_LINE))) ovf_next = 1'b1;
          complete = 1'b1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase

    // Sprite completion: close the layer on leap, then advance or finish
    if (complete) begin
      idx_next = idx_reg + IW'(1);
      if (cur_leap) begin
        layer_end_next = layer_hot;
        layer_next     = layer_after;
      end
      if ((idx_reg == IW'(SPR_NUM - 1)) || (cur_leap && (layer_reg == LW'(LAYERS - 1)))) begin
        state_next     = DONE;
        layer_end_next = layer_end_next | tail_mask;
      end else begin
        state_next = RD0;
      end
    end

    if (start) begin
      state_next     = en ? RD0 : IDLE;
      idx_next       = '0;
      layer_next     = '0;
      spr_cnt_next   = '0;
      ovf_next       = 1'b0;
      offset_next    = '0;
      leap_next      = 1'b0;
      cull_next      = 1'b0;
      tsr_x_next     = '0;
      tsr_xs_next    = '0;
      tsr_xf_next    = 1'b0;
      tsr_line_next  = '0;
      tsr_addr_next  = '0;
      tsr_pal_next   = '0;
      layer_end_next = en ? '0 : '1;
      sf_addr        = '0;
      tsr_go         = 1'b0;
    end
  end

  assign busy      = (state_reg != IDLE) && (state_reg != DONE);
  assign ovf       = ovf_reg;
  assign spr_cnt   = spr_cnt_reg;
  assign tsr_x     = tsr_x_reg;
  assign tsr_xs    = tsr_xs_reg;
  assign tsr_xf    = tsr_xf_reg;
  assign tsr_line  = tsr_line_reg;
  assign tsr_addr  = tsr_addr_reg;
  assign tsr_pal   = tsr_pal_reg;
  assign layer_end = layer_end_reg;

endmodule

// File: tb/tb_video_ts_spr_scan.sv
// Directed bench for the sprite-line scanner: a default instance plus a
// second instance with a 2-sprite line cap, both reading one sprite file.
module tb_video_ts_spr_scan;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        en = 1'b0;
  logic [8:0]  line = 9'd0;
  logic        tsr_rdy = 1'b1;

  logic [7:0]  sf_addr, c_sf_addr;
  logic [15:0] sf_rdata, c_sf_rdata;
  logic        tsr_go, c_tsr_go;
  logic [8:0]  tsr_x, c_tsr_x;
  logic [2:0]  tsr_xs, c_tsr_xs;
  logic        tsr_xf, c_tsr_xf;
  logic [8:0]  tsr_line, c_tsr_line;
  logic [5:0]  tsr_addr, c_tsr_addr;
  logic [3:0]  tsr_pal, c_tsr_pal;
  logic [2:0]  layer_end, c_layer_end;
  logic        busy, c_busy;
  logic        ovf, c_ovf;
  logic [6:0]  spr_cnt, c_spr_cnt;

  logic [15:0] sf_mem [0:255];

  int n_vec = 0;
  int n_miss = 0;

  // monitor state
  int          cyc = 0;
  int          t0 = 0;
  int          go_n = 0;
  int          cgo_n = 0;
  int          le_n = 0;
  int          go_lat [16];
  int          go_le [16];
  logic [8:0]  go_line [16];
  logic [8:0]  go_x [16];
  logic [5:0]  go_addr [16];
  logic [3:0]  go_pal [16];
  logic [2:0]  le_log [16];
  logic [8:0]  hold_line;
  logic [8:0]  hold_x;

  video_ts_spr_scan dut (
    .clk(clk), .rst_n(rst_n), .start(start), .en(en), .line(line),
    .sf_addr(sf_addr), .sf_rdata(sf_rdata), .tsr_rdy(tsr_rdy), .tsr_go(tsr_go),
    .tsr_x(tsr_x), .tsr_xs(tsr_xs), .tsr_xf(tsr_xf), .tsr_line(tsr_line),
    .tsr_addr(tsr_addr), .tsr_pal(tsr_pal), .layer_end(layer_end), .busy(busy),
    .ovf(ovf), .spr_cnt(spr_cnt)
  );

  video_ts_spr_scan #(.MAX_PER_LINE(2)) dut_cap (
    .clk(clk), .rst_n(rst_n), .start(start), .en(en), .line(line),
    .sf_addr(c_sf_addr), .sf_rdata(c_sf_rdata), .tsr_rdy(tsr_rdy), .tsr_go(c_tsr_go),
    .tsr_x(c_tsr_x), .tsr_xs(c_tsr_xs), .tsr_xf(c_tsr_xf), .tsr_line(c_tsr_line),
    .tsr_addr(c_tsr_addr), .tsr_pal(c_tsr_pal), .layer_end(c_layer_end), .busy(c_busy),
    .ovf(c_ovf), .spr_cnt(c_spr_cnt)
  );

  always #5 clk = ~clk;

  // Sprite file with registered read for each instance
  always @(posedge clk) begin
    sf_rdata   <= sf_mem[sf_addr];
    c_sf_rdata <= sf_mem[c_sf_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Negedge monitor: log tasks and layer_end pulses, one line per task
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (start) t0 = cyc;
      if (tsr_go && go_n < 16) begin
        go_lat[go_n]  = cyc - t0;
        go_le[go_n]   = le_n;
        go_line[go_n] = tsr_line;
        go_x[go_n]    = tsr_x;
        go_addr[go_n] = tsr_addr;
        go_pal[go_n]  = tsr_pal;
        $display("task %0d: lat=%0d x=%0d line=%0d addr=%0d pal=%0d layer_ends_before=%0d",
                 go_n, cyc - t0, tsr_x, tsr_line, tsr_addr, tsr_pal, le_n);
        go_n++;
      end
      if (c_tsr_go) cgo_n++;
      if (layer_end != 3'b000 && le_n < 16) begin
        le_log[le_n] = layer_end;
        le_n++;
      end
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) sf_mem[i] = 16'h0000;
  endtask

  task automatic set_spr(input int n, input logic [15:0] r0, input logic [15:0] r1, input logic [15:0] r2);
    sf_mem[3*n]   = r0;
    sf_mem[3*n+1] = r1;
    sf_mem[3*n+2] = r2;
  endtask

  task automatic pulse_start(input logic en_v);
    go_n = 0;
    cgo_n = 0;
    le_n = 0;
    @(posedge clk); #1;
    en = en_v;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("scan_done", busy, 0);
    repeat (2) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    clear_mem();
    line = 9'd15;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sf_addr", sf_addr, 0);
    chk("rst_go", tsr_go, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_cnt", spr_cnt, 0);
    chk("rst_le", layer_end, 0);
    chk("rst_line", tsr_line, 0);
    rst_n = 1'b1;

    // Visible sprite, immediate accept
    set_spr(0, 16'h220A, 16'h0064, 16'h30C5);
    pulse_start(1'b1);
    chk("vis_busy", busy, 1);
    wait_idle();
    chk("vis_go_n", go_n, 1);
    chk("vis_lat", go_lat[0], 5);
    chk("vis_line", go_line[0], 9'h01D);
    chk("vis_addr", go_addr[0], 5);
    chk("vis_x", go_x[0], 100);
    chk("vis_pal", go_pal[0], 3);
    chk("vis_cnt", spr_cnt, 1);
    chk("vis_le_n", le_n, 1);
    chk("vis_le_done", le_log[0], 3'b111);

    // Y flip
    set_spr(0, 16'hA20A, 16'h0064, 16'h30C5);
    pulse_start(1'b1);
    wait_idle();
    chk("flip_go_n", go_n, 1);
    chk("flip_line", go_line[0], 34);

    // Layer split: leap on the second of three sprites
    set_spr(0, 16'h220A, 16'h0064, 16'h30C5);
    set_spr(1, 16'h620A, 16'h0064, 16'h30C5);
    set_spr(2, 16'h220A, 16'h0064, 16'h30C5);
    pulse_start(1'b1);
    wait_idle();
    chk("split_go_n", go_n, 3);
    chk("split_go1_layer", go_le[1], 0);
    chk("split_go2_layer", go_le[2], 1);
    chk("split_le_n", le_n, 2);
    chk("split_le0", le_log[0], 3'b001);
    chk("split_le1", le_log[1], 3'b110);

    // Line cap: five visible sprites, cap of 2 on the second instance
    clear_mem();
    for (int i = 0; i < 5; i++) set_spr(i, 16'h220A, 16'h0064, 16'h30C5);
    pulse_start(1'b1);
    wait_idle();
    chk("cap_go_n", cgo_n, 2);
    chk("cap_ovf", c_ovf, 1);
    chk("cap_cnt", c_spr_cnt, 2);
    chk("nocap_go_n", go_n, 5);
    chk("nocap_ovf", ovf, 0);
    chk("nocap_cnt", spr_cnt, 5);

    // X culling: wholly off to the right, then wrapping into view
    clear_mem();
    set_spr(0, 16'h220A, 16'h0190, 16'h30C5);
    pulse_start(1'b1);
    wait_idle();
    chk("cull_go_n", go_n, 0);
    set_spr(0, 16'h220A, 16'h01FC, 16'h30C5);
    pulse_start(1'b1);
    wait_idle();
    chk("wrap_go_n", go_n, 1);
    chk("wrap_x", go_x[0], 508);

    // Stall in EMIT on sprite 2, then restart with start and rdy together
    clear_mem();
    set_spr(2, 16'h220A, 16'h0064, 16'h30C5);
    tsr_rdy = 1'b0;
    pulse_start(1'b1);
    repeat (8) begin
      @(posedge clk); #1;
    end
    hold_line = tsr_line;
    hold_x = tsr_x;
    chk("stall_line", tsr_line, 9'h01D);
    repeat (10) begin
      @(posedge clk); #1;
    end
    chk("stall_go_n", go_n, 0);
    chk("stall_line_hold", tsr_line, hold_line);
    chk("stall_x_hold", tsr_x, hold_x);
    chk("stall_busy", busy, 1);
    start = 1'b1;
    tsr_rdy = 1'b1;
    #1;
    chk("start_wins", tsr_go, 0);
    @(posedge clk); #1;
    start = 1'b0;
    chk("restart_addr", sf_addr, 0);
    chk("restart_x_clr", tsr_x, 0);
    wait_idle();
    chk("restart_go_n", go_n, 1);
    chk("restart_lat", go_lat[0], 9);

    // Asynchronous reset mid-scan, while a task is being offered
    pulse_start(1'b1);
    repeat (8) begin
      @(posedge clk); #1;
    end
    chk("pre_rst_go", tsr_go, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_go", tsr_go, 0);
    chk("arst_busy", busy, 0);
    chk("arst_x", tsr_x, 0);
    chk("arst_line", tsr_line, 0);
    chk("arst_sf_addr", sf_addr, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Start with sprites disabled: all layers end on the next cycle
    pulse_start(1'b0);
    chk("dis_le", layer_end, 3'b111);
    chk("dis_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
